// File: rtl/tpu_core.sv
// Weight-stationary NxN systolic matrix multiplier with register-file operand
// buffers and an overwrite/accumulate result buffer committed on done.
module tpu_core #(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32,
  localparam int unsigned AW    = $clog2(N * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_we,
  input  logic [AW-1:0]     w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              start,
  input  logic              acc_mode,
  input  logic [AW-1:0]     r_addr,
  output logic [ACC_W-1:0]  r_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NN  = N * N;
  localparam int unsigned AW1 = AW + 1;
  localparam int unsigned PW  = 2 * DATA_W;
  localparam int unsigned CYC = 3 * N;
  localparam int unsigned CW  = $clog2(CYC);

  localparam logic [AW:0]   NN_L       = AW1'(NN);
  localparam logic [CW-1:0] CNT_COMMIT = CW'(CYC - 2);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CYC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          acc_l, acc_l_d;
  logic          busy_d, done_d;
  logic          commit_c;

  logic signed [DATA_W-1:0] a_mem   [NN];
  logic signed [DATA_W-1:0] w_mem   [NN];
  logic signed [ACC_W-1:0]  res_mem [NN];

  logic signed [DATA_W-1:0] a_feed [N];
  logic signed [DATA_W-1:0] a_in   [N][N];
  logic signed [DATA_W-1:0] a_pipe [N][N];
  logic signed [ACC_W-1:0]  p_in   [N][N];
  logic signed [ACC_W-1:0]  psum   [N][N];
  logic signed [PW-1:0]     prod   [N][N];
  logic signed [ACC_W-1:0]  c_stage [NN];
  logic signed [ACC_W-1:0]  c_now   [NN];

  function automatic logic in_range(input logic [AW-1:0] addr);
    return {1'b0, addr} < NN_L;
  endfunction

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc_l <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      acc_l <= acc_l_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // Next-state: RUN lasts 3N cycles; results commit one cycle before leaving RUN
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    acc_l_d  = acc_l;
    done_d   = 1'b0;
    commit_c = 1'b0;
    busy_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_l_d = acc_mode;
        end
      end
      RUN: begin
        cnt_d = cnt + CW'(1);
        if (cnt == CNT_COMMIT) begin
          commit_c = 1'b1;
          done_d   = 1'b1;
        end
        if (cnt == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  // Skewed activation feed: row k sees A[i][k] in cycle i+k
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      a_feed[k] = '0;
      for (int unsigned i = 0; i < N; i++) begin
        if (32'(cnt) == i + k) a_feed[k] = a_mem[i*N + k];
      end
    end
  end

  // PE interconnect: activations move right, partial sums move down
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      a_in[k][0] = a_feed[k];
      for (int unsigned j = 1; j < N; j++) a_in[k][j] = a_pipe[k][j-1];
    end
    for (int unsigned j = 0; j < N; j++) begin
      p_in[0][j] = '0;
      for (int unsigned k = 1; k < N; k++) p_in[k][j] = psum[k-1][j];
    end
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned j = 0; j < N; j++) begin
        prod[k][j] = PW'(a_in[k][j]) * PW'(w_mem[k*N + j]);
      end
    end
  end

  // C[i][j] leaves the bottom of column j during cycle i+j+N
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        c_now[i*N + j] = (32'(cnt) == i + j + N) ? psum[N-1][j] : c_stage[i*N + j];
      end
    end
  end

  // Systolic array and output staging
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < N; k++) begin
        for (int unsigned j = 0; j < N; j++) begin
          a_pipe[k][j] <= '0;
          psum[k][j]   <= '0;
        end
      end
      for (int unsigned e = 0; e < NN; e++) c_stage[e] <= '0;
    end else if (state == RUN) begin
      for (int unsigned k = 0; k < N; k++) begin
        for (int unsigned j = 0; j < N; j++) begin
          a_pipe[k][j] <= a_in[k][j];
          psum[k][j]   <= p_in[k][j] + ACC_W'(prod[k][j]);
        end
      end
      for (int unsigned e = 0; e < NN; e++) c_stage[e] <= c_now[e];
    end
  end

  // Operand buffers, result buffer and registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned e = 0; e < NN; e++) begin
        a_mem[e]   <= '0;
        w_mem[e]   <= '0;
        res_mem[e] <= '0;
      end
      r_data <= '0;
    end else begin
      if (state == IDLE && a_we && in_range(a_addr)) a_mem[a_addr] <= a_data;
      if (state == IDLE && w_we && in_range(w_addr)) w_mem[w_addr] <= w_data;
      if (commit_c) begin
        for (int unsigned e = 0; e < NN; e++) begin
          res_mem[e] <= acc_l ? res_mem[e] + c_now[e] : c_now[e];
        end
      end
      r_data <= in_range(r_addr) ? res_mem[r_addr] : '0;
    end
  end

endmodule

// File: tb/tb_tpu_core.sv
// Self-checking bench for tpu_core: matmul model, per-cycle busy/done/r_data
// timing checks and a queued scoreboard for result readback.
module tb_tpu_core;

  localparam int unsigned N      = 2;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned NN     = N * N;
  localparam int unsigned AW     = $clog2(NN);

  logic              clk = 1'b0;
  logic              reset;
  logic              w_we, a_we, start, acc_mode;
  logic [AW-1:0]     w_addr, a_addr, r_addr;
  logic [DATA_W-1:0] w_data, a_data;
  logic [ACC_W-1:0]  r_data;
  logic              busy, done;

  int n_checks = 0;
  int n_errors = 0;

  int               a_m   [NN];
  int               w_m   [NN];
  logic [ACC_W-1:0] res_m [NN];
  logic [ACC_W-1:0] c_exp [NN];
  logic [ACC_W-1:0] sb_q  [$];

  tpu_core #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .a_we(a_we), .a_addr(a_addr), .a_data(a_data),
    .start(start), .acc_mode(acc_mode),
    .r_addr(r_addr), .r_data(r_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr_a(input int idx, input int val);
    a_we = 1'b1; a_addr = AW'(idx); a_data = DATA_W'(val);
    @(negedge clk);
    a_we = 1'b0;
    a_m[idx] = val;
  endtask

  task automatic wr_w(input int idx, input int val);
    w_we = 1'b1; w_addr = AW'(idx); w_data = DATA_W'(val);
    @(negedge clk);
    w_we = 1'b0;
    w_m[idx] = val;
  endtask

  task automatic load_a(input int x0, input int x1, input int x2, input int x3);
    wr_a(0, x0); wr_a(1, x1); wr_a(2, x2); wr_a(3, x3);
  endtask

  task automatic load_w(input int x0, input int x1, input int x2, input int x3);
    wr_w(0, x0); wr_w(1, x1); wr_w(2, x2); wr_w(3, x3);
  endtask

  task automatic compute_exp(input bit acc);
    logic [ACC_W-1:0] s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) begin
          s = s + ACC_W'(longint'(a_m[i*N + k]) * longint'(w_m[k*N + j]));
        end
        c_exp[i*N + j] = acc ? res_m[i*N + j] + s : s;
      end
    end
  endtask

  // One computation; per-cycle checks after edge T+m. Optional same-edge write,
  // injected start/write while busy, and reset driven at cycle rst_at.
  task automatic run_mat(input bit acc, input bit inject, input int pre_idx,
                         input int pre_val, input int rst_at, input int last_m);
    logic [ACC_W-1:0] old_last;
    bit dead;
    old_last = res_m[NN-1];
    r_addr   = AW'(NN - 1);
    start    = 1'b1;
    acc_mode = acc;
    if (pre_idx >= 0) begin
      a_we = 1'b1; a_addr = AW'(pre_idx); a_data = DATA_W'(pre_val);
      a_m[pre_idx] = pre_val;
    end
    @(negedge clk);
    start = 1'b0;
    a_we  = 1'b0;
    compute_exp(acc);
    for (int m = 0; m <= last_m; m++) begin
      dead = (rst_at >= 0) && (m > rst_at);
      check($sformatf("busy@%0d", m), 64'(busy), dead ? 64'd0 : 64'(m <= 3*N - 1));
      check($sformatf("done@%0d", m), 64'(done), dead ? 64'd0 : 64'(m == 3*N - 1));
      check($sformatf("rd_run@%0d", m), 64'(r_data),
            dead ? 64'd0 : ((m <= 3*N - 1) ? 64'(old_last) : 64'(c_exp[NN-1])));
      if (inject) begin
        if (m == 1) start = 1'b1;
        if (m == 2) begin
          start = 1'b0; a_we = 1'b1; a_addr = '0; a_data = DATA_W'(99);
        end
        if (m == 3) a_we = 1'b0;
      end
      if (m == rst_at) reset = 1'b1;
      if (rst_at >= 0 && m == rst_at + 1) reset = 1'b0;
      if (m < last_m) @(negedge clk);
    end
    if (rst_at < 0) begin
      for (int e = 0; e < NN; e++) res_m[e] = c_exp[e];
    end else begin
      for (int e = 0; e < NN; e++) begin
        a_m[e] = 0; w_m[e] = 0; res_m[e] = '0;
      end
    end
  endtask

  // Pipelined readback: expectation queued with each address, compared a cycle later
  task automatic readback();
    for (int idx = 0; idx <= NN; idx++) begin
      if (sb_q.size() > 0) check($sformatf("res[%0d]", idx - 1), 64'(r_data), 64'(sb_q.pop_front()));
      if (idx < NN) begin
        r_addr = AW'(idx);
        sb_q.push_back(res_m[idx]);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; w_we = 1'b0; a_we = 1'b0; start = 1'b0; acc_mode = 1'b0;
    w_addr = '0; a_addr = '0; r_addr = '0; w_data = '0; a_data = '0;
    for (int e = 0; e < NN; e++) begin
      a_m[e] = 0; w_m[e] = 0; res_m[e] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rdata", 64'(r_data), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic product, then accumulate with the same operands
    load_a(1, 2, 3, 4);
    load_w(5, 6, 7, 8);
    run_mat(1'b0, 1'b0, -1, 0, -1, 3*N + 2);
    readback();
    run_mat(1'b1, 1'b0, -1, 0, -1, 3*N + 2);
    readback();

    // Negative activations, weights reused
    load_a(-1, 0, 0, -1);
    run_mat(1'b0, 1'b0, -1, 0, -1, 3*N + 2);
    readback();

    // Most-negative operands wrap the accumulator
    load_a(-32768, -32768, -32768, -32768);
    load_w(-32768, -32768, -32768, -32768);
    run_mat(1'b0, 1'b0, -1, 0, -1, 3*N + 2);
    readback();

    // Start and write while busy are ignored; the ignored write must not stick
    load_a(1, 2, 3, 4);
    load_w(5, 6, 7, 8);
    run_mat(1'b0, 1'b1, -1, 0, -1, 3*N + 2);
    readback();
    run_mat(1'b0, 1'b0, -1, 0, -1, 3*N + 2);
    readback();

    // Back-to-back start right after done, with a write on the start edge
    run_mat(1'b0, 1'b0, -1, 0, -1, 3*N);
    run_mat(1'b1, 1'b0, 1, 7, -1, 3*N + 2);
    readback();

    // Random operands and modes
    for (int t = 0; t < 3; t++) begin
      for (int e = 0; e < NN; e++) begin
        wr_a(e, int'($urandom_range(0, 65535)) - 32768);
        wr_w(e, int'($urandom_range(0, 65535)) - 32768);
      end
      run_mat(1'(t % 2), 1'b0, -1, 0, -1, 3*N + 2);
      readback();
    end

    // Reset mid-run aborts with no done and clears every buffer
    load_a(1, 2, 3, 4);
    load_w(5, 6, 7, 8);
    run_mat(1'b0, 1'b0, -1, 0, 2, 3*N + 2);
    readback();
    run_mat(1'b0, 1'b0, -1, 0, -1, 3*N + 2);
    readback();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
